// File: rtl/clock_div_pkg.sv
// Shared definitions for the clock divider controller.
// Holds the controller state encoding and the default sizing values used by
// clock_divider_ctrl and div_counter.
package clock_div_pkg;

    localparam int unsigned DEF_COUNTER_SIZE = 24;
    localparam int unsigned DEF_LIMIT        = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/div_counter.sv
// Half-period counter and divided-clock toggle.
// Ports:
//   clock, reset       system clock, synchronous active-high reset
//   enable             count this cycle
//   clear              synchronous clear of counter and div_clock
//   limit              half-period limit (half-period = limit+1 cycles)
//   div_clock          registered divided clock
//   wrap_rise          this edge wraps and takes div_clock 0->1
//   wrap_fall          this edge wraps and takes div_clock 1->0
module div_counter
    import clock_div_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_COUNTER_SIZE
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [WIDTH-1:0] limit,
    output logic             div_clock,
    output logic             wrap_rise,
    output logic             wrap_fall
);

    logic [WIDTH-1:0] count;
    logic             at_limit;

    assign at_limit  = (count == limit);
    assign wrap_rise = enable && at_limit && !div_clock;
    assign wrap_fall = enable && at_limit && div_clock;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count     <= '0;
            div_clock <= 1'b0;
        end else if (enable) begin
            if (at_limit) begin
                count     <= '0;
                div_clock <= !div_clock;
            end else begin
                count <= count + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/clock_divider_ctrl.sv
// Clock divider controller: start/stop FSM, single-slot limit configuration
// and optional burst mode around a div_counter instance.
// Optional feature macro: CLOCK_DIV_CTRL_BURST_EN (adds burst_len/burst_done).
// Ports:
//   clock, reset       system clock, synchronous active-high reset
//   cfg_valid/ready    limit handshake; cfg_limit is the offered limit
//   start, stop        begin generation / graceful stop at end of period
//   burst_len          (burst build) periods per run, 0 = continuous
//   burst_done         (burst build) one-cycle pulse when a burst completes
//   div_clock          registered divided clock
//   tick               one-cycle pulse while div_clock has just risen
//   busy               high in RUN or DRAIN
module clock_divider_ctrl
    import clock_div_pkg::*;
#(
    parameter int unsigned COUNTER_SIZE  = DEF_COUNTER_SIZE,
    parameter int unsigned DEFAULT_LIMIT = DEF_LIMIT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cfg_valid,
    input  logic [COUNTER_SIZE-1:0] cfg_limit,
    output logic                    cfg_ready,
    input  logic                    start,
    input  logic                    stop,
`ifdef CLOCK_DIV_CTRL_BURST_EN
    input  logic [7:0]              burst_len,
    output logic                    burst_done,
`endif
    output logic                    div_clock,
    output logic                    tick,
    output logic                    busy
);

    state_t                  state;
    logic [COUNTER_SIZE-1:0] limit;
    logic [COUNTER_SIZE-1:0] pending_limit;
    logic                    pending;
    logic                    cnt_enable;
    logic                    cnt_clear;
    logic                    wrap_rise;
    logic                    wrap_fall;
`ifdef CLOCK_DIV_CTRL_BURST_EN
    logic [7:0]              burst_rem;
`endif

    assign cfg_ready  = !pending;
    assign cnt_enable = (state != IDLE);
    // Holding the counter cleared in IDLE guarantees every run starts at
    // counter=0/div_clock=0 and that a limit change never sees a stale count.
    assign cnt_clear  = (state == IDLE);

    div_counter #(
        .WIDTH(COUNTER_SIZE)
    ) u_counter (
        .clock    (clock),
        .reset    (reset),
        .enable   (cnt_enable),
        .clear    (cnt_clear),
        .limit    (limit),
        .div_clock(div_clock),
        .wrap_rise(wrap_rise),
        .wrap_fall(wrap_fall)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            limit         <= COUNTER_SIZE'(DEFAULT_LIMIT);
            pending_limit <= '0;
            pending       <= 1'b0;
            tick          <= 1'b0;
            busy          <= 1'b0;
`ifdef CLOCK_DIV_CTRL_BURST_EN
            burst_rem     <= '0;
            burst_done    <= 1'b0;
`endif
        end else begin
            tick <= wrap_rise;
`ifdef CLOCK_DIV_CTRL_BURST_EN
            burst_done <= 1'b0;
`endif

            // Capture and apply are mutually exclusive: capture needs an
            // empty slot, apply needs a full one.
            if (cfg_valid && !pending) begin
                pending       <= 1'b1;
                pending_limit <= cfg_limit;
            end
            // Only swap the limit while the counter is (or is about to be)
            // zero, so no period is truncated.
            if (pending && (state == IDLE || wrap_fall)) begin
                limit   <= pending_limit;
                pending <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        state <= RUN;
                        busy  <= 1'b1;
`ifdef CLOCK_DIV_CTRL_BURST_EN
                        burst_rem <= burst_len;
`endif
                    end
                end
                RUN: begin
`ifdef CLOCK_DIV_CTRL_BURST_EN
                    if (wrap_fall && burst_rem == 8'd1) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        burst_done <= 1'b1;
                    end else begin
                        if (wrap_fall && burst_rem > 8'd1) begin
                            burst_rem <= burst_rem - 8'd1;
                        end
                        if (stop) begin
                            state <= DRAIN;
                        end
                    end
`else
                    if (stop) begin
                        state <= DRAIN;
                    end
`endif
                end
                DRAIN: begin
                    if (wrap_fall) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
